apb_master_bridge: RTL and testbench

APB initiator that turns a simple valid/ready request from the system-side front end (same PCLK domain) into APB3 transfers to up to NSLV peripheral slaves (GPIO, timer, UART, ...). It decodes the target slave from the address, sequences SETUP/ACCESS phases and muxes PRDATA/PREADY/PSLVERR back. It returns a single-cycle response carrying read data and an error flag. A wait-state timeout guarantees every request completes.

---
 rtl/apb_master_bridge.sv | 131 +++++++++++++
 tb/tb_apb_master_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a single valid/ready request into one SETUP/ACCESS transfer
// to the slave chosen by req_addr[15:12], then returns a one-cycle response.
module apb_master_bridge #(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [NSLV-1:0]     PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [31:0]         PADDR,
    output logic [31:0]         PWDATA,
    input  logic [NSLV*32-1:0]  PRDATA,
    input  logic [NSLV-1:0]     PREADY,
    input  logic [NSLV-1:0]     PSLVERR
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 4;
    // Wait count at which the next low PREADY edge is the last one allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               sel_ready;
    logic               sel_err;
    logic [31:0]        sel_rdata;
    logic               timeout_hit;
    logic               decode_err;

    assign req_ready   = (state == IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    assign decode_err  = (32'(req_addr[15:12]) >= NSLV);

    // Return-path mux for the slave captured at accept time.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[32*i +: 32];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        PWRITE   <= req_write;
                        PADDR    <= req_addr;
                        PWDATA   <= req_wdata;
                        idx      <= req_addr[15:12];
                        wait_cnt <= '0;
                        if (decode_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            PSEL  <= NSLV'(1) << req_addr[15:12];
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_err;
                        rsp_rdata <= PWRITE ? 32'd0 : sel_rdata;
                    end else if (timeout_hit) begin
                        // Slave never answered: abandon it and report an error.
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (NSLV=4, TIMEOUT=8) with simple wait-state slaves.
module tb_apb_master_bridge;

    localparam int unsigned NSLV = 4;

    logic                PCLK = 1'b0;
    logic                PRESETn;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [NSLV-1:0]     PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [31:0]         PADDR;
    logic [31:0]         PWDATA;
    logic [NSLV*32-1:0]  PRDATA;
    logic [NSLV-1:0]     PREADY;
    logic [NSLV-1:0]     PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    int slv_wait [NSLV];
    int acc_cyc;

    // Results of the last run_req
    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_ready;
    int          r_en;
    int          r_setup;
    logic [3:0]  r_psel;
    logic        r_stable;

    apb_master_bridge #(.NSLV(NSLV), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: PREADY rises after slv_wait ACCESS cycles.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) acc_cyc <= 0;
        else if (PENABLE) acc_cyc <= acc_cyc + 1;
        else acc_cyc <= 0;
    end

    always_comb begin
        for (int i = 0; i < NSLV; i++) PREADY[i] = (acc_cyc >= slv_wait[i]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        r_lat = 1; r_en = 0; r_setup = 0; r_psel = '0; r_stable = 1'b1;
        while (!rsp_valid && r_lat < 40) begin
            if (PENABLE) r_en++;
            if (PSEL != 0 && !PENABLE) r_setup++;
            r_psel |= PSEL;
            if (PSEL != 0 && (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr))
                r_stable = 1'b0;
            @(negedge PCLK);
            r_lat++;
        end
        check("rsp_seen", 32'(rsp_valid), 32'd1);
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        r_ready = req_ready;
    endtask

    initial begin
        logic [7:0] psel_trace;
        int         rsp_cnt;

        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PSLVERR   = '0;
        for (int i = 0; i < NSLV; i++) slv_wait[i] = 0;
        repeat (3) @(negedge PCLK);

        check("rst_psel",    32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite",  32'(PWRITE), 32'd0);
        check("rst_paddr",   PADDR, 32'd0);
        check("rst_pwdata",  PWDATA, 32'd0);
        check("rst_rsp",     {rsp_rdata[30:0], rsp_valid}, 32'd0);
        check("rst_err",     32'(rsp_err), 32'd0);
        check("rst_ready",   32'(req_ready), 32'd1);
        PRESETn = 1'b1;

        // Zero-wait read from slave 0
        PRDATA[31:0] = 32'h0000_ABCD;
        PRDATA[127:96] = 32'hDEAD_0003;
        run_req(1'b0, 32'h0000_0004, 32'h0);
        check("rd_lat",   32'(r_lat), 32'd3);
        check("rd_data",  r_rdata, 32'h0000_ABCD);
        check("rd_err",   32'(r_err), 32'd0);
        check("rd_setup", 32'(r_setup), 32'd1);
        check("rd_en",    32'(r_en), 32'd1);
        check("rd_psel",  32'(r_psel), 32'h1);
        check("rd_ready", 32'(r_ready), 32'd1);

        // Write with 3 wait states to slave 2
        slv_wait[2] = 3;
        PRDATA[95:64] = 32'hDEAD_0002;
        run_req(1'b1, 32'h0000_2000, 32'h0000_5A5A);
        check("wr_lat",    32'(r_lat), 32'd6);
        check("wr_en",     32'(r_en), 32'd4);
        check("wr_stable", 32'(r_stable), 32'd1);
        check("wr_data",   r_rdata, 32'd0);
        check("wr_err",    32'(r_err), 32'd0);
        check("wr_psel",   32'(r_psel), 32'h4);
        @(negedge PCLK);
        check("idle_hold_pwdata", PWDATA, 32'h0000_5A5A);
        check("idle_hold_paddr",  PADDR, 32'h0000_2000);
        check("rsp_one_cycle",    32'(rsp_valid), 32'd0);
        check("rsp_data_hold",    rsp_rdata, 32'd0);

        // Slave error on slave 1
        PSLVERR[1] = 1'b1;
        PRDATA[63:32] = 32'h1111_2222;
        run_req(1'b0, 32'h0000_1008, 32'h0);
        check("serr_lat",  32'(r_lat), 32'd3);
        check("serr_err",  32'(r_err), 32'd1);
        check("serr_data", r_rdata, 32'h1111_2222);
        check("serr_psel", 32'(r_psel), 32'h2);
        PSLVERR[1] = 1'b0;

        // Decode error
        run_req(1'b0, 32'h0000_7000, 32'h0);
        check("dec_lat",   32'(r_lat), 32'd1);
        check("dec_err",   32'(r_err), 32'd1);
        check("dec_data",  r_rdata, 32'd0);
        check("dec_psel",  32'(r_psel), 32'd0);
        check("dec_ready", 32'(r_ready), 32'd1);

        // Timeout on slave 3 (never ready)
        slv_wait[3] = 1000;
        run_req(1'b0, 32'h0000_3010, 32'h0);
        check("to_en",    32'(r_en), 32'd8);
        check("to_lat",   32'(r_lat), 32'd10);
        check("to_err",   32'(r_err), 32'd1);
        check("to_data",  r_rdata, 32'd0);
        check("to_ready", 32'(r_ready), 32'd1);
        check("to_psel_drop", {31'd0, PENABLE} | 32'(PSEL), 32'd0);

        // Back-to-back reads with req_valid held, reset during 3rd ACCESS
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0010;
        psel_trace = '0;
        rsp_cnt = 0;
        @(posedge PCLK);
        for (int c = 1; c <= 8; c++) begin
            @(negedge PCLK);
            psel_trace[c-1] = (PSEL != 0);
            if (rsp_valid) rsp_cnt++;
        end
        check("b2b_psel_trace", 32'(psel_trace), 32'h0000_00DB);
        check("b2b_rsp_cnt",    32'(rsp_cnt), 32'd2);
        check("b2b_in_access",  32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_mid_psel",    32'(PSEL), 32'd0);
        check("rst_mid_penable", 32'(PENABLE), 32'd0);
        check("rst_mid_rsp",     32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        rsp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            if (rsp_valid) rsp_cnt++;
        end
        check("rst_no_rsp",    32'(rsp_cnt), 32'd0);
        check("rst_rel_ready", 32'(req_ready), 32'd1);
        check("rst_rel_psel",  32'(PSEL), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
